// File: rtl/metronome_pkg.sv
// metronome_pkg -- shared constants and helpers for the metronome_bar block.
// Holds the default parameter values, the tempo-button delta magnitudes and
// the accumulator width function used to size the beat phase accumulator.
package metronome_pkg;

  // Default parameter values for metronome_bar.
  localparam int DEF_CLK_HZ   = 50_000_000;
  localparam int DEF_BPM_W    = 9;
  localparam int DEF_BPM_MIN  = 30;
  localparam int DEF_BPM_MAX  = 300;
  localparam int DEF_BPM_INIT = 120;
  localparam int DEF_FAST_BPM = 200;
  localparam int DEF_BEATS_W  = 3;

  // Tempo step sizes applied by the +/-1 and +/-5 buttons.
  localparam int DELTA_SMALL = 1;
  localparam int DELTA_LARGE = 5;

  // Accumulator width: it must hold 60*clk_hz (one beat worth of phase, since
  // the tempo is in beats per minute) plus one maximum tempo step. The product
  // overflows 32 bits at realistic clock rates, so work in 64 bits.
  function automatic int acc_width(input longint unsigned clk_hz,
                                   input longint unsigned bpm_max);
    longint unsigned span;
    span = 64'd60 * clk_hz + bpm_max;
    return $clog2(span);
  endfunction

endpackage

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher -- stretches a one-cycle trigger into a HOLD-cycle LED
// drive. The LED rises in the cycle after i_trig is sampled, stays high for
// HOLD cycles, and a trigger during the hold reloads the full count.
module led_pulse_stretcher
  import metronome_pkg::*;
#(
  parameter int HOLD = 5
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_trig,
  output logic o_led
);

  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             led_q;
  logic             led_d;

  // Next-state: reload on trigger, otherwise count the remaining hold down.
  always_comb begin
    cnt_d = cnt_q;
    led_d = led_q;
    if (i_trig) begin
      led_d = 1'b1;
      cnt_d = CNT_W'(HOLD - 1);
    end else if (cnt_q != '0) begin
      led_d = 1'b1;
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      led_d = 1'b0;
      cnt_d = '0;
    end
  end

  // Hold counter and LED register; reset drops the LED immediately.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign o_led = led_q;

endmodule

// File: rtl/metronome_bar.sv
// metronome_bar -- tempo-adjustable metronome with bar/accent tracking.
// Four tempo buttons (edge detected, summed, saturated) set the tempo in BPM.
// A phase accumulator adds the tempo every running cycle and emits a beat
// whenever one minute's worth of cycles (60*CLK_HZ) of phase has built up.
// Optional feature: define METRONOME_OFFBEAT_EN to add o_offbeat, a pulse at
// the half-beat point of each beat period.
module metronome_bar
  import metronome_pkg::*;
#(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int BPM_W    = DEF_BPM_W,
  parameter int BPM_MIN  = DEF_BPM_MIN,
  parameter int BPM_MAX  = DEF_BPM_MAX,
  parameter int BPM_INIT = DEF_BPM_INIT,
  parameter int FAST_BPM = DEF_FAST_BPM,
  parameter int BEATS_W  = DEF_BEATS_W,
  parameter int LED_HOLD = CLK_HZ / 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_btn_plus_1,
  input  logic               i_btn_plus_5,
  input  logic               i_btn_minus_1,
  input  logic               i_btn_minus_5,
  input  logic               i_run,
  input  logic [BEATS_W-1:0] i_beats_per_bar,
  output logic [BPM_W-1:0]   o_bpm,
  output logic               o_beat,
  output logic               o_accent,
  output logic [BEATS_W-1:0] o_beat_idx,
  output logic               o_led_beat,
  output logic               o_led_accent,
  output logic               o_led_fast
`ifdef METRONOME_OFFBEAT_EN
  ,
  output logic               o_offbeat
`endif
);

  localparam int ACC_W = acc_width(longint'(CLK_HZ), longint'(BPM_MAX));
  localparam logic [ACC_W-1:0] PERIOD = ACC_W'(64'd60 * 64'(CLK_HZ));
  localparam logic [ACC_W-1:0] HALF   = ACC_W'(64'd30 * 64'(CLK_HZ));
  // Two guard bits: one for the sign, one for headroom above BPM_MAX.
  localparam int SUM_W = BPM_W + 2;

  // Button bits are packed as {plus_1, plus_5, minus_1, minus_5}.
  logic [3:0]              btn_s;
  logic [3:0]              btn_q;
  logic [3:0]              edge_s;

  logic signed [SUM_W-1:0] delta_s;
  logic signed [SUM_W-1:0] bpm_sum_s;
  logic [BPM_W-1:0]        bpm_q;
  logic [BPM_W-1:0]        bpm_d;

  logic                    run_q;
  logic                    run_start_s;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;
  logic [ACC_W-1:0]        acc_sum_s;
  logic [BEATS_W-1:0]      idx_q;
  logic [BEATS_W-1:0]      idx_d;
  logic                    beat_q;
  logic                    beat_d;
  logic                    accent_q;
  logic                    accent_d;
  logic                    fast_q;
  logic                    fast_d;
  logic                    led_beat_s;
  logic                    led_accent_s;

  assign btn_s  = {i_btn_plus_1, i_btn_plus_5, i_btn_minus_1, i_btn_minus_5};
  assign edge_s = btn_s & ~btn_q;

  // Tempo update: sum all simultaneous button edges, then saturate.
  always_comb begin
    delta_s = '0;
    if (edge_s[3]) begin
      delta_s = delta_s + $signed(SUM_W'(DELTA_SMALL));
    end else begin
      delta_s = delta_s;
    end
    if (edge_s[2]) begin
      delta_s = delta_s + $signed(SUM_W'(DELTA_LARGE));
    end else begin
      delta_s = delta_s;
    end
    if (edge_s[1]) begin
      delta_s = delta_s - $signed(SUM_W'(DELTA_SMALL));
    end else begin
      delta_s = delta_s;
    end
    if (edge_s[0]) begin
      delta_s = delta_s - $signed(SUM_W'(DELTA_LARGE));
    end else begin
      delta_s = delta_s;
    end

    bpm_sum_s = $signed({2'b00, bpm_q}) + delta_s;
    if (bpm_sum_s < $signed(SUM_W'(BPM_MIN))) begin
      bpm_d = BPM_W'(BPM_MIN);
    end else if (bpm_sum_s > $signed(SUM_W'(BPM_MAX))) begin
      bpm_d = BPM_W'(BPM_MAX);
    end else begin
      bpm_d = bpm_sum_s[BPM_W-1:0];
    end

    fast_d = (bpm_d >= BPM_W'(FAST_BPM));
  end

  // Beat engine: phase accumulation, beat/accent generation, bar position.
  // The accumulation always uses the tempo currently on o_bpm, so a tempo
  // change lands on the following accumulation without clearing the phase.
  always_comb begin
    run_start_s = i_run & ~run_q;
    acc_sum_s   = acc_q + ACC_W'(bpm_q);
    acc_d       = acc_q;
    idx_d       = idx_q;
    beat_d      = 1'b0;
    accent_d    = 1'b0;
    if (!i_run) begin
      acc_d = '0;
      idx_d = '0;
    end else if (run_start_s) begin
      // Starting the metronome plays the downbeat straight away.
      acc_d    = '0;
      idx_d    = '0;
      beat_d   = 1'b1;
      accent_d = 1'b1;
    end else if (acc_sum_s >= PERIOD) begin
      acc_d  = acc_sum_s - PERIOD;
      beat_d = 1'b1;
      // ">=" rather than "==" so a bar shortened mid-way wraps on the next beat.
      if ((i_beats_per_bar <= BEATS_W'(1)) ||
          (idx_q >= i_beats_per_bar - BEATS_W'(1))) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + BEATS_W'(1);
      end
      accent_d = (idx_d == '0);
    end else begin
      acc_d = acc_sum_s;
    end
  end

  // State registers; reset preloads the button history with the live levels
  // so a button held through reset produces no edge afterwards.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      btn_q    <= btn_s;
      bpm_q    <= BPM_W'(BPM_INIT);
      run_q    <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      beat_q   <= 1'b0;
      accent_q <= 1'b0;
      fast_q   <= 1'b0;
    end else begin
      btn_q    <= btn_s;
      bpm_q    <= bpm_d;
      run_q    <= i_run;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      beat_q   <= beat_d;
      accent_q <= accent_d;
      fast_q   <= fast_d;
    end
  end

  // The stretchers are fed the next-state pulses so each LED rises in the
  // same cycle as its pulse output; an accent also retriggers the beat LED.
  led_pulse_stretcher #(.HOLD(LED_HOLD)) u_led_beat (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_trig  (beat_d | accent_d),
    .o_led   (led_beat_s)
  );

  led_pulse_stretcher #(.HOLD(LED_HOLD)) u_led_accent (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_trig  (accent_d),
    .o_led   (led_accent_s)
  );

`ifdef METRONOME_OFFBEAT_EN
  logic offbeat_q;
  logic offbeat_d;

  // Off-beat: the accumulation step that carries the phase across the
  // half-period mark without wrapping, while the metronome is already running.
  always_comb begin
    if (i_run && run_q && (acc_sum_s < PERIOD) &&
        (acc_q < HALF) && (acc_sum_s >= HALF)) begin
      offbeat_d = 1'b1;
    end else begin
      offbeat_d = 1'b0;
    end
  end

  // Off-beat pulse register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      offbeat_q <= 1'b0;
    end else begin
      offbeat_q <= offbeat_d;
    end
  end

  assign o_offbeat = offbeat_q;
`endif

  assign o_bpm        = bpm_q;
  assign o_beat       = beat_q;
  assign o_accent     = accent_q;
  assign o_beat_idx   = idx_q;
  assign o_led_beat   = led_beat_s;
  assign o_led_accent = led_accent_s;
  assign o_led_fast   = fast_q;

endmodule
